// File: rtl/stream_arb_pkg.sv
// ============================================================================
// Module      : stream_arb_pkg
// Description : Shared types, constants and helpers for the round-robin
//               stream arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int CNT_W = 16;

    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_rr_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker: first set request bit at or
//               after ptr, wrapping modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import stream_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       any,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int                 c_idx_w = $clog2(NUM_REQ);
    localparam logic [c_idx_w-1:0] c_last  = c_idx_w'(NUM_REQ - 1);

    logic [c_idx_w-1:0] w_k;

    always_comb begin
        any = 1'b0;
        idx = '0;
        w_k = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && req[w_k]) begin
                any = 1'b1;
                idx = w_k;
            end
            w_k = (w_k == c_last) ? '0 : w_k + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/stream_rr_arbiter.sv
// ============================================================================
// Module      : stream_rr_arbiter
// Description : Packet-locked round-robin arbiter sharing one valid/ready byte
//               stream among NUM_REQ requesters, with a beat watchdog.
//               Optional per-requester packet counters: STREAM_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_last,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_last,
    input  logic                        out_ready,
    output logic [$clog2(NUM_REQ)-1:0]  grant_idx,
    output logic                        busy,
    output logic                        overrun,
    output logic [NUM_REQ*CNT_W-1:0]    grant_count
);

    localparam int                  c_idx_w    = $clog2(NUM_REQ);
    localparam int                  c_bcnt_w   = $clog2(MAX_BEATS + 1);
    localparam logic [c_bcnt_w-1:0] c_beat_lim = c_bcnt_w'(MAX_BEATS - 1);

    arb_state_t          r_state;
    logic [c_idx_w-1:0]  r_rr_ptr;
    logic [c_idx_w-1:0]  r_grant_idx;
    logic [c_bcnt_w-1:0] r_beat_cnt;
    logic                r_overrun;

    logic                w_any;
    logic [c_idx_w-1:0]  w_pick_idx;
    logic                w_busy;
    logic                w_beat;
    logic                w_limit;
    logic                w_pkt_end;
    logic [DATA_W-1:0]   w_req_data [NUM_REQ];

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
            assign w_req_data[i] = req_data[i*DATA_W +: DATA_W];
        end
    endgenerate

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req (req_valid),
        .ptr (r_rr_ptr),
        .any (w_any),
        .idx (w_pick_idx)
    );

    assign w_busy = (r_state == ARB_BUSY);

    // Owner passthrough; everything reads as zero outside a packet
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        req_ready = '0;
        if (w_busy) begin
            out_valid              = req_valid[r_grant_idx];
            out_data               = w_req_data[r_grant_idx];
            out_last               = req_last[r_grant_idx];
            req_ready[r_grant_idx] = out_ready;
        end
    end

    assign w_beat    = out_valid & out_ready;
    assign w_limit   = (r_beat_cnt == c_beat_lim);
    assign w_pkt_end = w_beat & (out_last | w_limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ARB_IDLE;
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_beat_cnt  <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_grant_idx <= w_pick_idx;
                        r_state     <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (w_pkt_end) begin
                        r_state    <= ARB_IDLE;
                        r_rr_ptr   <= c_idx_w'(rr_next(int'(r_grant_idx), NUM_REQ));
                        r_beat_cnt <= '0;
                        // A last beat landing on the limit is a normal end
                        r_overrun  <= ~out_last;
                    end else if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign grant_idx = r_grant_idx;
    assign busy      = w_busy;
    assign overrun   = r_overrun;

`ifdef STREAM_ARB_STATS_EN
    logic [CNT_W-1:0] r_grant_cnt [NUM_REQ];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_grant_cnt[i] <= '0;
            end
        end else if (w_pkt_end && (r_grant_cnt[r_grant_idx] != '1)) begin
            r_grant_cnt[r_grant_idx] <= r_grant_cnt[r_grant_idx] + 1'b1;
        end
    end

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt_out
            assign grant_count[i*CNT_W +: CNT_W] = r_grant_cnt[i];
        end
    endgenerate
`else
    assign grant_count = '0;
`endif

endmodule

`default_nettype wire
